// File: rtl/voice_allocator.sv
// Voice allocator: maps note-on/note-off events onto VOICE_COUNT synthesis pipelines
// (retrigger matching note > lowest free voice > steal oldest busy voice).
// Latency: accept at edge T, strobe visible after edge T+VOICE_COUNT, ready again one cycle later.
// Backpressure: event_ready is high only in IDLE; a held event_valid waits there, fields held stable.
//
// Ports:
//   clock_50_000_000, reset       - single clock, asynchronous active-high reset
//   event_valid/ready/on/note/velocity - input event handshake and fields
//   sustain                       - pedal level (VOICE_ALLOCATOR_SUSTAIN_EN builds only)
//   voice_strobe/on/note/velocity/stolen - one-cycle registered dispatch to a pipeline
//   voice_active                  - per-voice busy bits
// Optional feature macro: VOICE_ALLOCATOR_SUSTAIN_EN (sustain pedal defers note-offs).

module voice_allocator #(
    parameter int VOICE_COUNT    = 8,
    parameter int NOTE_WIDTH     = 7,
    parameter int VELOCITY_WIDTH = 7,
    parameter int AGE_WIDTH      = 8
) (
    input  logic                      clock_50_000_000,
    input  logic                      reset,
    input  logic                      event_valid,
    output logic                      event_ready,
    input  logic                      event_on,
    input  logic [NOTE_WIDTH-1:0]     event_note,
    input  logic [VELOCITY_WIDTH-1:0] event_velocity,
    input  logic                      sustain,
    output logic [VOICE_COUNT-1:0]    voice_strobe,
    output logic                      voice_on,
    output logic [NOTE_WIDTH-1:0]     voice_note,
    output logic [VELOCITY_WIDTH-1:0] voice_velocity,
    output logic                      voice_stolen,
    output logic [VOICE_COUNT-1:0]    voice_active
);

    localparam int IW = (VOICE_COUNT > 1) ? $clog2(VOICE_COUNT) : 1;
    localparam logic [IW-1:0]          LAST_IDX = IW'(VOICE_COUNT - 1);
    localparam logic [AGE_WIDTH-1:0]   AGE_MAX  = '1;
    localparam logic [VOICE_COUNT-1:0] ONE_HOT0 = VOICE_COUNT'(1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SEARCH  = 2'd1,
`ifdef VOICE_ALLOCATOR_SUSTAIN_EN
        ST_ISSUE   = 2'd2,
        ST_RELEASE = 2'd3
`else
        ST_ISSUE   = 2'd2
`endif
    } state_t;

    state_t state_q, state_d;
    logic [IW-1:0] idx_q, idx_d;

    // Captured event
    logic                      cap_on_q, cap_on_d;
    logic [NOTE_WIDTH-1:0]     cap_note_q, cap_note_d;
    logic [VELOCITY_WIDTH-1:0] cap_vel_q, cap_vel_d;

    // Running search results
    logic                 mt_vld_q, mt_vld_d;
    logic [IW-1:0]        mt_idx_q, mt_idx_d;
    logic                 fr_vld_q, fr_vld_d;
    logic [IW-1:0]        fr_idx_q, fr_idx_d;
    logic                 old_vld_q, old_vld_d;
    logic [IW-1:0]        old_idx_q, old_idx_d;
    logic [AGE_WIDTH-1:0] old_age_q, old_age_d;

    // Per-voice state
    logic [VOICE_COUNT-1:0] busy_q, busy_d;
    logic [NOTE_WIDTH-1:0]  note_q [VOICE_COUNT];
    logic [NOTE_WIDTH-1:0]  note_d [VOICE_COUNT];
    logic [AGE_WIDTH-1:0]   age_q  [VOICE_COUNT];
    logic [AGE_WIDTH-1:0]   age_d  [VOICE_COUNT];

    // Registered outputs
    logic [VOICE_COUNT-1:0]    strobe_q, strobe_d;
    logic                      von_q, von_d;
    logic [NOTE_WIDTH-1:0]     vnote_q, vnote_d;
    logic [VELOCITY_WIDTH-1:0] vvel_q, vvel_d;
    logic                      stolen_q, stolen_d;

    // Search view including the voice examined this cycle
    logic                 m_vld, f_vld, o_vld;
    logic [IW-1:0]        m_idx, f_idx, o_idx;
    logic [AGE_WIDTH-1:0] o_age;
    logic [IW-1:0]        tgt;
    logic                 eff_on;
    logic                 defer_off;

`ifdef VOICE_ALLOCATOR_SUSTAIN_EN
    logic                   cap_sus_q, cap_sus_d;
    logic [VOICE_COUNT-1:0] held_q, held_d;
    logic                   sus_q, sus_dly_q;
    logic                   pend_q, pend_d;
    logic                   sus_fall;
    logic                   rel_vld;
    logic [IW-1:0]          rel_idx;

    assign sus_fall  = sus_dly_q & ~sus_q;
    assign defer_off = cap_sus_q;

    // Lowest-index held voice is released first
    always_comb begin
        rel_vld = 1'b0;
        rel_idx = '0;
        for (int i = VOICE_COUNT - 1; i >= 0; i--) begin
            if (held_q[i]) begin
                rel_vld = 1'b1;
                rel_idx = IW'(i);
            end
        end
    end
`else
    logic unused_sustain;
    assign unused_sustain = sustain;
    assign defer_off      = 1'b0;
`endif

    // Velocity-0 note-on is a note-off
    assign eff_on = cap_on_q && (cap_vel_q != '0);

    always_comb begin
        m_vld = mt_vld_q;
        m_idx = mt_idx_q;
        f_vld = fr_vld_q;
        f_idx = fr_idx_q;
        o_vld = old_vld_q;
        o_idx = old_idx_q;
        o_age = old_age_q;
        if (!mt_vld_q && busy_q[idx_q] && (note_q[idx_q] == cap_note_q)) begin
            m_vld = 1'b1;
            m_idx = idx_q;
        end
        if (!fr_vld_q && !busy_q[idx_q]) begin
            f_vld = 1'b1;
            f_idx = idx_q;
        end
        // Strictly greater keeps the lowest index on ties
        if (busy_q[idx_q] && (!old_vld_q || (age_q[idx_q] > old_age_q))) begin
            o_vld = 1'b1;
            o_idx = idx_q;
            o_age = age_q[idx_q];
        end
    end

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        cap_on_d   = cap_on_q;
        cap_note_d = cap_note_q;
        cap_vel_d  = cap_vel_q;
        mt_vld_d   = mt_vld_q;
        mt_idx_d   = mt_idx_q;
        fr_vld_d   = fr_vld_q;
        fr_idx_d   = fr_idx_q;
        old_vld_d  = old_vld_q;
        old_idx_d  = old_idx_q;
        old_age_d  = old_age_q;
        busy_d     = busy_q;
        note_d     = note_q;
        age_d      = age_q;
        strobe_d   = '0;
        stolen_d   = 1'b0;
        von_d      = von_q;
        vnote_d    = vnote_q;
        vvel_d     = vvel_q;
        tgt        = '0;
`ifdef VOICE_ALLOCATOR_SUSTAIN_EN
        cap_sus_d  = cap_sus_q;
        held_d     = held_q;
        pend_d     = pend_q | sus_fall;
`endif

        case (state_q)
            ST_IDLE: begin
                if (event_valid) begin
                    cap_on_d   = event_on;
                    cap_note_d = event_note;
                    cap_vel_d  = event_velocity;
                    mt_vld_d   = 1'b0;
                    fr_vld_d   = 1'b0;
                    old_vld_d  = 1'b0;
                    mt_idx_d   = '0;
                    fr_idx_d   = '0;
                    old_idx_d  = '0;
                    old_age_d  = '0;
                    idx_d      = '0;
                    state_d    = ST_SEARCH;
`ifdef VOICE_ALLOCATOR_SUSTAIN_EN
                    cap_sus_d  = sustain;
                end else if (pend_q) begin
                    pend_d  = 1'b0;
                    state_d = ST_RELEASE;
`endif
                end
            end

            ST_SEARCH: begin
                mt_vld_d  = m_vld;
                mt_idx_d  = m_idx;
                fr_vld_d  = f_vld;
                fr_idx_d  = f_idx;
                old_vld_d = o_vld;
                old_idx_d = o_idx;
                old_age_d = o_age;
                if (idx_q != LAST_IDX) begin
                    idx_d = idx_q + IW'(1);
                end else begin
                    // Decision taken on the last scan cycle so the outputs are
                    // registered and visible during ISSUE.
                    state_d = ST_ISSUE;
                    if (eff_on) begin
                        if (m_vld) begin
                            tgt = m_idx;
                        end else begin
                            tgt      = f_vld ? f_idx : o_idx;
                            stolen_d = !f_vld;
                            for (int i = 0; i < VOICE_COUNT; i++) begin
                                if (busy_q[i] && (IW'(i) != tgt) && (age_q[i] != AGE_MAX)) begin
                                    age_d[i] = age_q[i] + AGE_WIDTH'(1);
                                end
                            end
                            busy_d[tgt] = 1'b1;
                            note_d[tgt] = cap_note_q;
                            age_d[tgt]  = '0;
                        end
`ifdef VOICE_ALLOCATOR_SUSTAIN_EN
                        held_d[tgt] = 1'b0;
`endif
                        strobe_d = ONE_HOT0 << tgt;
                        von_d    = 1'b1;
                        vnote_d  = cap_note_q;
                        vvel_d   = cap_vel_q;
                    end else if (m_vld) begin
                        if (!defer_off) begin
                            strobe_d      = ONE_HOT0 << m_idx;
                            von_d         = 1'b0;
                            vnote_d       = cap_note_q;
                            vvel_d        = cap_vel_q;
                            busy_d[m_idx] = 1'b0;
                            age_d[m_idx]  = '0;
                        end
`ifdef VOICE_ALLOCATOR_SUSTAIN_EN
                        held_d[m_idx] = defer_off;
`endif
                    end
                end
            end

            ST_ISSUE: begin
`ifdef VOICE_ALLOCATOR_SUSTAIN_EN
                if (pend_d) begin
                    pend_d  = 1'b0;
                    state_d = ST_RELEASE;
                end else begin
                    state_d = ST_IDLE;
                end
`else
                state_d = ST_IDLE;
`endif
            end

`ifdef VOICE_ALLOCATOR_SUSTAIN_EN
            ST_RELEASE: begin
                if (rel_vld) begin
                    strobe_d        = ONE_HOT0 << rel_idx;
                    von_d           = 1'b0;
                    vnote_d         = note_q[rel_idx];
                    vvel_d          = '0;
                    busy_d[rel_idx] = 1'b0;
                    held_d[rel_idx] = 1'b0;
                    age_d[rel_idx]  = '0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
`endif

            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock_50_000_000 or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            idx_q      <= '0;
            cap_on_q   <= 1'b0;
            cap_note_q <= '0;
            cap_vel_q  <= '0;
            mt_vld_q   <= 1'b0;
            mt_idx_q   <= '0;
            fr_vld_q   <= 1'b0;
            fr_idx_q   <= '0;
            old_vld_q  <= 1'b0;
            old_idx_q  <= '0;
            old_age_q  <= '0;
            busy_q     <= '0;
            for (int i = 0; i < VOICE_COUNT; i++) begin
                note_q[i] <= '0;
                age_q[i]  <= '0;
            end
            strobe_q   <= '0;
            von_q      <= 1'b0;
            vnote_q    <= '0;
            vvel_q     <= '0;
            stolen_q   <= 1'b0;
`ifdef VOICE_ALLOCATOR_SUSTAIN_EN
            cap_sus_q  <= 1'b0;
            held_q     <= '0;
            sus_q      <= 1'b0;
            sus_dly_q  <= 1'b0;
            pend_q     <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            cap_on_q   <= cap_on_d;
            cap_note_q <= cap_note_d;
            cap_vel_q  <= cap_vel_d;
            mt_vld_q   <= mt_vld_d;
            mt_idx_q   <= mt_idx_d;
            fr_vld_q   <= fr_vld_d;
            fr_idx_q   <= fr_idx_d;
            old_vld_q  <= old_vld_d;
            old_idx_q  <= old_idx_d;
            old_age_q  <= old_age_d;
            busy_q     <= busy_d;
            note_q     <= note_d;
            age_q      <= age_d;
            strobe_q   <= strobe_d;
            von_q      <= von_d;
            vnote_q    <= vnote_d;
            vvel_q     <= vvel_d;
            stolen_q   <= stolen_d;
`ifdef VOICE_ALLOCATOR_SUSTAIN_EN
            cap_sus_q  <= cap_sus_d;
            held_q     <= held_d;
            sus_q      <= sustain;
            sus_dly_q  <= sus_q;
            pend_q     <= pend_d;
`endif
        end
    end

    assign event_ready    = (state_q == ST_IDLE);
    assign voice_strobe   = strobe_q;
    assign voice_on       = von_q;
    assign voice_note     = vnote_q;
    assign voice_velocity = vvel_q;
    assign voice_stolen   = stolen_q;
    assign voice_active   = busy_q;

endmodule

// File: tb/tb_voice_allocator.sv
`timescale 1ns/1ps
module tb_voice_allocator;

    localparam int VC      = 4;
    localparam int NW      = 7;
    localparam int VW      = 7;
    localparam int AW      = 2;
    localparam int AGE_MAX = (1 << AW) - 1;

    logic          clk = 1'b0;
    logic          reset;
    logic          event_valid;
    logic          event_ready;
    logic          event_on;
    logic [NW-1:0] event_note;
    logic [VW-1:0] event_velocity;
    logic          sustain;
    logic [VC-1:0] voice_strobe;
    logic          voice_on;
    logic [NW-1:0] voice_note;
    logic [VW-1:0] voice_velocity;
    logic          voice_stolen;
    logic [VC-1:0] voice_active;

    voice_allocator #(
        .VOICE_COUNT(VC), .NOTE_WIDTH(NW), .VELOCITY_WIDTH(VW), .AGE_WIDTH(AW)
    ) dut (
        .clock_50_000_000(clk),
        .reset(reset),
        .event_valid(event_valid),
        .event_ready(event_ready),
        .event_on(event_on),
        .event_note(event_note),
        .event_velocity(event_velocity),
        .sustain(sustain),
        .voice_strobe(voice_strobe),
        .voice_on(voice_on),
        .voice_note(voice_note),
        .voice_velocity(voice_velocity),
        .voice_stolen(voice_stolen),
        .voice_active(voice_active)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [VC-1:0] strobe;
        logic          on;
        logic [NW-1:0] note;
        logic [VW-1:0] vel;
        logic          stolen;
        logic [VC-1:0] active;
        int            cyc;    // -1: cycle not pinned
    } exp_t;

    exp_t expq[$];

    // Reference model: what each voice holds
    bit m_busy [VC];
    int m_note [VC];
    int m_age  [VC];
    bit m_held [VC];

    function automatic logic [VC-1:0] model_active();
        logic [VC-1:0] a;
        for (int i = 0; i < VC; i++) a[i] = m_busy[i];
        return a;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < VC; i++) begin
            m_busy[i] = 0; m_note[i] = 0; m_age[i] = 0; m_held[i] = 0;
        end
    endtask

    task automatic push_exp(input int v, input logic on, input int note, input int vel,
                            input logic stolen, input int when);
        exp_t e;
        e.strobe = '0;
        e.strobe[v] = 1'b1;
        e.on = on; e.note = NW'(note); e.vel = VW'(vel);
        e.stolen = stolen; e.active = model_active(); e.cyc = when;
        expq.push_back(e);
    endtask

    // Apply one accepted event; t is the accept edge number
    task automatic model_event(input logic on, input int note, input int vel,
                               input logic sus, input int t);
        int match, free, oldest, tgt;
        match = -1; free = -1; oldest = -1;
        for (int i = 0; i < VC; i++) begin
            if (m_busy[i] && m_note[i] == note && match < 0) match = i;
            if (!m_busy[i] && free < 0) free = i;
            if (m_busy[i] && (oldest < 0 || m_age[i] > m_age[oldest])) oldest = i;
        end
        if (on && vel != 0) begin
            if (match >= 0) begin
                m_held[match] = 0;
                push_exp(match, 1'b1, note, vel, 1'b0, t + VC);
            end else begin
                tgt = (free >= 0) ? free : oldest;
                for (int i = 0; i < VC; i++)
                    if (m_busy[i] && i != tgt && m_age[i] < AGE_MAX) m_age[i]++;
                m_busy[tgt] = 1; m_note[tgt] = note; m_age[tgt] = 0; m_held[tgt] = 0;
                push_exp(tgt, 1'b1, note, vel, free < 0, t + VC);
            end
        end else if (match >= 0) begin
`ifdef VOICE_ALLOCATOR_SUSTAIN_EN
            if (sus) begin
                m_held[match] = 1;
                return;
            end
`endif
            m_busy[match] = 0; m_age[match] = 0; m_held[match] = 0;
            push_exp(match, 1'b0, note, vel, 1'b0, t + VC);
        end
    endtask

`ifdef VOICE_ALLOCATOR_SUSTAIN_EN
    task automatic model_release();
        for (int i = 0; i < VC; i++) begin
            if (m_held[i]) begin
                m_busy[i] = 0; m_age[i] = 0; m_held[i] = 0;
                push_exp(i, 1'b0, m_note[i], 0, 1'b0, -1);
            end
        end
    endtask
`endif

    // Monitor: every strobe must match the head of the scoreboard
    always @(negedge clk) begin
        exp_t e;
        if (!reset && voice_strobe != '0) begin
            checks++;
            if (expq.size() == 0) begin
                errors++;
                $display("FAIL unexpected_strobe @%0d: got strobe=%b note=%0d, expected no strobe",
                         cyc, voice_strobe, voice_note);
            end else begin
                e = expq.pop_front();
                if ({voice_strobe, voice_on, voice_note, voice_velocity, voice_stolen, voice_active}
                    !== {e.strobe, e.on, e.note, e.vel, e.stolen, e.active}) begin
                    errors++;
                    $display("FAIL strobe_fields @%0d: got strobe=%b on=%b note=%0d vel=%0d stolen=%b active=%b, expected strobe=%b on=%b note=%0d vel=%0d stolen=%b active=%b",
                             cyc, voice_strobe, voice_on, voice_note, voice_velocity, voice_stolen, voice_active,
                             e.strobe, e.on, e.note, e.vel, e.stolen, e.active);
                end
                if (e.cyc >= 0) begin
                    checks++;
                    if (cyc != e.cyc) begin
                        errors++;
                        $display("FAIL strobe_timing: got strobe at cycle %0d, expected %0d", cyc, e.cyc);
                    end
                end
            end
        end
    end

    task automatic check_quiet(input string name);
        checks++;
        if (voice_strobe !== '0 || voice_on !== 1'b0 || voice_note !== '0 || voice_velocity !== '0 ||
            voice_stolen !== 1'b0 || voice_active !== '0 || event_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s: got strobe=%b on=%b note=%0d vel=%0d stolen=%b active=%b ready=%b, expected all zero and ready=1",
                     name, voice_strobe, voice_on, voice_note, voice_velocity, voice_stolen, voice_active, event_ready);
        end
    endtask

    // Called and returns at a falling edge
    task automatic send(input logic on, input int note, input int vel);
        int t, waited;
        logic ok;
        event_on = on; event_note = NW'(note); event_velocity = VW'(vel); event_valid = 1'b1;
        waited = 0;
        while (!event_ready && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        checks++;
        if (!event_ready) begin
            errors++;
            $display("FAIL ready_timeout: got event_ready=0 for %0d cycles, expected 1", waited);
            event_valid = 1'b0;
            return;
        end
        t = cyc + 1;
        model_event(on, note, vel, sustain, t);
        @(negedge clk);
        event_valid = 1'b0;
        ok = 1'b1;
        for (int k = 0; k <= VC; k++) begin
            if (event_ready) ok = 1'b0;
            @(negedge clk);
        end
        if (!event_ready) ok = 1'b0;
        if (!ok) begin
            errors++;
            $display("FAIL ready_timing: got ready high during busy window or low at T+%0d, expected low then high", VC + 2);
        end
        checks++;
        if (voice_active !== model_active()) begin
            errors++;
            $display("FAIL active_after_event: got %b, expected %b", voice_active, model_active());
        end
    endtask

    initial begin
        int n;
        reset = 1'b1; event_valid = 1'b0; event_on = 1'b0; event_note = '0;
        event_velocity = '0; sustain = 1'b0;
        model_clear();
        repeat (3) @(negedge clk);
        check_quiet("reset_state");
        reset = 1'b0;
        @(negedge clk);

        // Reset during SEARCH aborts without a strobe
        event_valid = 1'b1; event_on = 1'b1; event_note = 7'd72; event_velocity = 7'd10;
        @(negedge clk);
        event_valid = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check_quiet("reset_mid_search");
        reset = 1'b0;
        repeat (VC + 3) @(negedge clk);
        check_quiet("reset_abort_idle");

        // Allocation, steal, retrigger, dropped and velocity-0 note-offs
        send(1'b1, 60, 100);
        send(1'b1, 62, 90);
        send(1'b1, 64, 70);
        send(1'b1, 65, 60);
        send(1'b1, 67, 55);
        send(1'b1, 62, 33);
        send(1'b1, 69, 44);
        send(1'b0, 70, 50);
        send(1'b1, 69, 0);
        send(1'b0, 64, 20);

`ifdef VOICE_ALLOCATOR_SUSTAIN_EN
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        model_clear();
        @(negedge clk);
        send(1'b1, 60, 100);
        send(1'b1, 62, 100);
        sustain = 1'b1;
        send(1'b0, 60, 0);
        send(1'b0, 62, 0);
        sustain = 1'b0;
        model_release();
        n = 0;
        while (voice_strobe == '0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (voice_strobe !== 4'b0001 || event_ready !== 1'b0) begin
            errors++;
            $display("FAIL release_first: got strobe=%b ready=%b, expected 0001 and 0", voice_strobe, event_ready);
        end
        @(negedge clk);
        checks++;
        if (voice_strobe !== 4'b0010 || event_ready !== 1'b0) begin
            errors++;
            $display("FAIL release_second: got strobe=%b ready=%b, expected 0010 and 0", voice_strobe, event_ready);
        end
        @(negedge clk);
        checks++;
        if (voice_strobe !== 4'b0000 || event_ready !== 1'b1 || voice_active !== 4'b0000) begin
            errors++;
            $display("FAIL release_done: got strobe=%b ready=%b active=%b, expected 0000 1 0000",
                     voice_strobe, event_ready, voice_active);
        end
`endif

        // Randomised traffic over a small note pool so matches and steals are frequent
        for (int k = 0; k < 150; k++) begin
            logic on;
            int note, vel;
            on   = ($urandom_range(0, 3) != 0);
            note = 60 + $urandom_range(0, 7);
            vel  = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 127);
            send(on, note, vel);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        repeat (4) @(negedge clk);
        checks++;
        if (expq.size() != 0) begin
            errors++;
            $display("FAIL missing_strobes: got %0d expected strobes never seen, expected 0", expq.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/voice_allocator.md
# voice_allocator

Polyphonic voice allocator between the MIDI decoder and the synthesis pipelines; parametrised successor of the fixed-count dispatch stage. It accepts note-on/note-off events over a valid/ready handshake and maps each one to one of `VOICE_COUNT` pipelines. Mapping rules, in priority order: retrigger a voice already holding the same note, take the lowest-index free voice, or steal the oldest voice. An optional sustain-pedal mode defers note-offs until the pedal is released.

## Interface
- `VOICE_COUNT`, 8: number of pipelines; must be ≥2.
- `NOTE_WIDTH`, 7: note number width.
- `VELOCITY_WIDTH`, 7: velocity width.
- `AGE_WIDTH`, 8: width of the saturating per-voice age counter.
- `clock_50_000_000`  in  1  system clock; the block's only clock.
- `reset`  in  1  asynchronous, active-high reset.
- `event_valid`  in  1  an input event is present.
- `event_ready`  out  1  allocator can accept an event.
- `event_on`  in  1  1 = note-on, 0 = note-off.
- `event_note`  in  NOTE_WIDTH  note number.
- `event_velocity`  in  VELOCITY_WIDTH  velocity.
- `sustain`  in  1  sustain pedal level; used only with `VOICE_ALLOCATOR_SUSTAIN_EN`.
- `voice_strobe`  out  VOICE_COUNT  one-hot, one-cycle pulse naming the target pipeline.
- `voice_on`  out  1  event type for the strobed voice.
- `voice_note`  out  NOTE_WIDTH  note for the strobed voice.
- `voice_velocity`  out  VELOCITY_WIDTH  velocity for the strobed voice.
- `voice_stolen`  out  1  pulses together with `voice_strobe` when the note-on stole a busy voice.
- `voice_active`  out  VOICE_COUNT  busy bit of each voice.

## Operation
- **Per-voice state:** `busy`, `note`, `age` (saturating at 2^AGE_WIDTH−1), and `held` (sustain mode only).
- **FSM states:** IDLE, SEARCH, ISSUE, RELEASE.
  - `event_ready` = (state == IDLE).
  - Handshake completes when `event_valid && event_ready` at a rising edge. The event fields are captured at that edge.
- **SEARCH:** scans voice index 0..VOICE_COUNT−1, one voice per cycle. It records:
  - the first busy voice whose note equals the captured note;
  - the first free voice;
  - the busy voice with maximum age (ties go to the lowest index).
- **ISSUE:** exactly one decision is made, and the outputs are registered.
- **Note-on with velocity 0** is treated as a note-off.
- **Note-on:**
  - If a voice matches, retrigger it: strobe that voice, ages unchanged.
  - Else if a voice is free, allocate it.
  - Else steal the oldest voice and pulse `voice_stolen`.
  - On allocation or steal: target `busy`=1, `note` captured, `age`=0, `held`=0. Every other busy voice increments `age`, saturating.
- **Note-off:**
  - If a voice matches and is not held, strobe it with `voice_on`=0, then clear `busy` and `age`.
  - If no voice matches, the event is dropped: no strobe, identical timing.
- **Reset:**
  - Outputs: `voice_strobe`=0, `voice_stolen`=0, `voice_on`=0, `voice_note`=0, `voice_velocity`=0, `voice_active`=0, `event_ready`=1.
  - Internal state: all voice state cleared, FSM in IDLE.
  - Reset asserted mid-SEARCH/ISSUE/RELEASE aborts the operation with no strobe.

## Timing
- Accept at edge T.
- SEARCH occupies cycles T+1..T+VOICE_COUNT.
- `voice_strobe` is high for exactly the one cycle T+VOICE_COUNT+1.
- `event_ready` is high again at T+VOICE_COUNT+2.
- Maximum throughput: one event per VOICE_COUNT+2 cycles.
- `voice_active` updates in the same cycle as the strobe.
- `event_valid` held while `event_ready`=0 is not consumed; the source must hold the fields stable until acceptance.

## Configuration
- **`VOICE_ALLOCATOR_SUSTAIN_EN` defined:**
  - While `sustain`=1, a matched note-off sets `held`=1 and produces no strobe. The voice stays busy and remains steal-eligible.
  - A note-on that retriggers a held voice clears `held`.
  - A registered 1→0 edge of `sustain` is latched. RELEASE is entered from IDLE, or after the ISSUE of an in-flight event.
  - RELEASE emits note-off strobes for held voices in ascending index order, one per consecutive cycle, clearing `busy`/`held`/`age`. It returns to IDLE the cycle after the last one; if no voice is held, it lasts one cycle with no strobe.
  - `event_ready`=0 throughout RELEASE.
  - Sustain rising again during RELEASE does not stop RELEASE.
- **Macro undefined:** `sustain` is ignored, `held` is not implemented, RELEASE does not exist, and all note-offs act immediately.

## Test plan
All scenarios use VOICE_COUNT=4.
- **Reset:** assert `reset` mid-SEARCH → no strobe, all outputs 0, `event_ready`=1 next cycle.
- **Basic allocation:** note-on 60 vel 100 accepted at T → `voice_strobe`=0001 at T+5, `voice_note`=60, `voice_on`=1, `voice_active`=0001; `event_ready` high at T+6.
- **Steal:** note-ons 60, 62, 64, 65, then 67 → 67 strobes 0001 with `voice_stolen`=1; `voice_active` stays 1111.
- **Retrigger:** note-on 62 while voice 1 holds 62 → strobe 0010, `voice_stolen`=0, no age changes; a subsequent steal still picks the oldest voice.
- **Note-off paths:**
  - note-off 70 (not held) → no strobe, `event_ready` returns at T+6;
  - note-on 60 vel 0 → strobe on 60's voice with `voice_on`=0 and that `voice_active` bit cleared.
- **Sustain (`VOICE_ALLOCATOR_SUSTAIN_EN`):** `sustain`=1, note-offs 60 (voice 0) and 62 (voice 1) → no strobes; drop `sustain` → strobes 0001 then 0010 on consecutive cycles with `voice_on`=0, `voice_active`=0000, `event_ready` low until done.
